// File: rtl/collision_scheduler_pkg.sv
// Shared definitions for the collision scheduler slice.
//   state_t        : pass sequencer states (IDLE=0, SLOT1=1, SLOT2=2, DONE=3)
//   COLL_W         : width of the collision unit result
//   X_/Y_/W_/H_*   : bit positions of the packed {x,y} position and {w,h} size words
package collision_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOT1 = 2'd1,
    ST_SLOT2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int COLL_W = 4;
  localparam int WORD_W = 32;

  // Position word {x[31:16], y[15:0]}
  localparam int X_HI = 31;
  localparam int X_LO = 16;
  localparam int Y_HI = 15;
  localparam int Y_LO = 0;

  // Size word {w[31:16], h[15:0]}
  localparam int W_HI = 31;
  localparam int W_LO = 16;
  localparam int H_HI = 15;
  localparam int H_LO = 0;

endpackage

// File: rtl/collision_scheduler_if.sv
// Bus bundle between the physics coprocessors, the shared collision unit and
// the collision scheduler.
//   frame_tick, p2_enable          : pass control
//   pos1/pos2, size1/size2         : player operands from the physics side
//   stage_pos_in/stage_size_in     : stage rectangle
//   coll_in                        : combinational result from the collision unit
//   player_*_out, stage_*_out      : operands driven into the collision unit
//   collis1/collis2                : latched, zero-extended results to physics `wall`
//   busy, done, overrun_count      : status
// modport master : the side driving the scheduler inputs
// modport slave  : the scheduler itself
interface collision_scheduler_if
  import collision_scheduler_pkg::*;
#(
  parameter int OVF_W = 8
) ();

  logic              frame_tick;
  logic              p2_enable;
  logic [WORD_W-1:0] pos1;
  logic [WORD_W-1:0] pos2;
  logic [WORD_W-1:0] size1;
  logic [WORD_W-1:0] size2;
  logic [WORD_W-1:0] stage_pos_in;
  logic [WORD_W-1:0] stage_size_in;
  logic [COLL_W-1:0] coll_in;
  logic [WORD_W-1:0] player_pos_out;
  logic [WORD_W-1:0] player_size_out;
  logic [WORD_W-1:0] stage_pos_out;
  logic [WORD_W-1:0] stage_size_out;
  logic [WORD_W-1:0] collis1;
  logic [WORD_W-1:0] collis2;
  logic              busy;
  logic              done;
  logic [OVF_W-1:0]  overrun_count;

  modport master (
    output frame_tick, p2_enable, pos1, pos2, size1, size2,
           stage_pos_in, stage_size_in, coll_in,
    input  player_pos_out, player_size_out, stage_pos_out, stage_size_out,
           collis1, collis2, busy, done, overrun_count
  );

  modport slave (
    input  frame_tick, p2_enable, pos1, pos2, size1, size2,
           stage_pos_in, stage_size_in, coll_in,
    output player_pos_out, player_size_out, stage_pos_out, stage_size_out,
           collis1, collis2, busy, done, overrun_count
  );

endinterface

// File: rtl/collision_scheduler_settle_timer.sv
// Per-slot settle window timer.
//   clock, reset : system clock, synchronous active-high reset
//   load         : restart the window (asserted on the edge entering a slot)
//   enable       : counting while a slot is active
//   expired      : high during the SETTLE-th cycle after load
module collision_scheduler_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  logic [3:0] count;

  // Count is 0 in the first cycle after load, so the SETTLE-th cycle sees SETTLE-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'd0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/collision_scheduler.sv
// Time-multiplexes the single collision unit between player 1 and player 2
// once per frame: snapshot both players on frame_tick, present each player's
// operands for SETTLE cycles, and latch the result into collis1/collis2.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : collision_scheduler_if slave modport (see interface header)
// Parameters: SETTLE (1..15) cycles per slot, OVF_W overrun counter width.
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int OVF_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  collision_scheduler_if.slave  bus
);

  state_t            state;
  logic [WORD_W-1:0] snap1, snap2, sz1, sz2;
  logic [WORD_W-1:0] stage_pos, stage_size;
  logic [WORD_W-1:0] collis1, collis2;
  logic              slot2_sel;
  logic              busy, done;
  logic [OVF_W-1:0]  ovf_cnt;
  logic              expired;
  logic              timer_load;
  logic              timer_en;
  logic [WORD_W-1:0] coll_ext;

  assign coll_ext   = {{(WORD_W - COLL_W){1'b0}}, bus.coll_in};
  assign timer_en   = (state == ST_SLOT1) || (state == ST_SLOT2);
  assign timer_load = ((state == ST_IDLE) && bus.frame_tick) ||
                      ((state == ST_SLOT1) && expired && bus.p2_enable);

  collision_scheduler_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      snap1      <= '0;
      snap2      <= '0;
      sz1        <= '0;
      sz2        <= '0;
      stage_pos  <= '0;
      stage_size <= '0;
      collis1    <= '0;
      collis2    <= '0;
      slot2_sel  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      done <= 1'b0;

      // Ticks arriving mid-pass (DONE included) are dropped and counted.
      if (bus.frame_tick && (state != ST_IDLE) && (ovf_cnt != {OVF_W{1'b1}})) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (bus.frame_tick) begin
            snap1      <= bus.pos1;
            snap2      <= bus.pos2;
            sz1        <= bus.size1;
            sz2        <= bus.size2;
            stage_pos  <= bus.stage_pos_in;
            stage_size <= bus.stage_size_in;
            slot2_sel  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SLOT1;
          end
        end
        ST_SLOT1: begin
          if (expired) begin
            collis1 <= coll_ext;
            if (bus.p2_enable) begin
              slot2_sel <= 1'b1;
              state     <= ST_SLOT2;
            end else begin
              // Skipped P2 slot must not leave a stale P2 result behind.
              collis2 <= '0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_SLOT2: begin
          if (expired) begin
            collis2 <= coll_ext;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operands keep showing the last driven slot while IDLE/DONE.
  assign bus.player_pos_out  = slot2_sel ? snap2 : snap1;
  assign bus.player_size_out = slot2_sel ? sz2   : sz1;
  assign bus.stage_pos_out   = stage_pos;
  assign bus.stage_size_out  = stage_size;
  assign bus.collis1         = collis1;
  assign bus.collis2         = collis2;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.overrun_count   = ovf_cnt;

endmodule

// File: tb/tb_collision_scheduler.sv
module tb_collision_scheduler;

  logic clock;
  logic reset;

  collision_scheduler_if #(.OVF_W(8)) bus ();

  collision_scheduler #(
    .SETTLE (2),
    .OVF_W  (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        tick;
    logic        p2en;
    logic [3:0]  coll;
    logic [31:0] pos1;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_c1;
    logic [31:0] e_c2;
    logic [31:0] e_ppos;
    logic [31:0] e_psize;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One active edge, then settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (bus.busy !== 1'b0 && cyc < 20) begin
      step();
      cyc++;
    end
    check({name, "_idle_timeout"}, 32'(bus.busy), 32'h0);
  endtask

  int done_seen;

  initial begin
    reset             = 1'b1;
    bus.frame_tick    = 1'b0;
    bus.p2_enable     = 1'b1;
    bus.pos1          = 32'h016000FA;
    bus.pos2          = 32'h00400020;
    bus.size1         = 32'h00100010;
    bus.size2         = 32'h00080008;
    bus.stage_pos_in  = 32'h11112222;
    bus.stage_size_in = 32'h33334444;
    bus.coll_in       = 4'h0;

    // Pass A (P1+P2) then pass B (P1 only). Rows: inputs before the edge,
    // expected outputs just after it.
    //              tick p2 coll  pos1          busy done c1     c2     ppos          psize
    vecs.push_back('{1'b1,1'b1,4'h0,32'h016000FA,1'b1,1'b0,32'h0,32'h0,32'h016000FA,32'h00100010});
    vecs.push_back('{1'b0,1'b1,4'h1,32'h00000000,1'b1,1'b0,32'h0,32'h0,32'h016000FA,32'h00100010});
    vecs.push_back('{1'b0,1'b1,4'h1,32'h00000000,1'b1,1'b0,32'h1,32'h0,32'h00400020,32'h00080008});
    vecs.push_back('{1'b0,1'b1,4'h8,32'h016000FA,1'b1,1'b0,32'h1,32'h0,32'h00400020,32'h00080008});
    vecs.push_back('{1'b0,1'b1,4'h8,32'h016000FA,1'b1,1'b1,32'h1,32'h8,32'h00400020,32'h00080008});
    vecs.push_back('{1'b0,1'b1,4'h0,32'h016000FA,1'b0,1'b0,32'h1,32'h8,32'h00400020,32'h00080008});
    vecs.push_back('{1'b0,1'b1,4'h0,32'h00AA00BB,1'b0,1'b0,32'h1,32'h8,32'h00400020,32'h00080008});
    vecs.push_back('{1'b1,1'b0,4'h0,32'h00AA00BB,1'b1,1'b0,32'h1,32'h8,32'h00AA00BB,32'h00100010});
    vecs.push_back('{1'b0,1'b0,4'h4,32'h00AA00BB,1'b1,1'b0,32'h1,32'h8,32'h00AA00BB,32'h00100010});
    vecs.push_back('{1'b0,1'b0,4'h4,32'h00AA00BB,1'b1,1'b1,32'h4,32'h0,32'h00AA00BB,32'h00100010});
    vecs.push_back('{1'b0,1'b0,4'h0,32'h00AA00BB,1'b0,1'b0,32'h4,32'h0,32'h00AA00BB,32'h00100010});
    vecs.push_back('{1'b0,1'b1,4'h0,32'h00AA00BB,1'b0,1'b0,32'h4,32'h0,32'h00AA00BB,32'h00100010});

    // Reset, then 10 idle cycles: everything must read zero.
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    check("rst_collis1", bus.collis1, 32'h0);
    check("rst_collis2", bus.collis2, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_overrun", 32'(bus.overrun_count), 32'h0);
    check("rst_ppos", bus.player_pos_out, 32'h0);
    check("rst_psize", bus.player_size_out, 32'h0);
    check("rst_stage_pos", bus.stage_pos_out, 32'h0);
    check("rst_stage_size", bus.stage_size_out, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.frame_tick = vecs[i].tick;
      bus.p2_enable  = vecs[i].p2en;
      bus.coll_in    = vecs[i].coll;
      bus.pos1       = vecs[i].pos1;
      step();
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_collis1", i), bus.collis1, vecs[i].e_c1);
      check($sformatf("vec%0d_collis2", i), bus.collis2, vecs[i].e_c2);
      check($sformatf("vec%0d_ppos", i), bus.player_pos_out, vecs[i].e_ppos);
      check($sformatf("vec%0d_psize", i), bus.player_size_out, vecs[i].e_psize);
    end
    bus.frame_tick = 1'b0;
    check("stage_pos", bus.stage_pos_out, 32'h11112222);
    check("stage_size", bus.stage_size_out, 32'h33334444);
    check("no_overrun_yet", 32'(bus.overrun_count), 32'h0);

    // Ticks at T, T+1, T+4: only the first starts a pass.
    bus.p2_enable = 1'b1;
    bus.coll_in   = 4'h2;
    done_seen     = 0;
    for (int c = 0; c < 12; c++) begin
      bus.frame_tick = (c == 0 || c == 1 || c == 4);
      step();
      if (bus.done === 1'b1) done_seen++;
    end
    bus.frame_tick = 1'b0;
    check("ovr_passes", 32'(done_seen), 32'h1);
    check("ovr_count2", 32'(bus.overrun_count), 32'h2);
    check("ovr_busy_after", 32'(bus.busy), 32'h0);

    // Continuous ticks: counter must saturate at 255, not wrap.
    bus.coll_in    = 4'h5;
    bus.frame_tick = 1'b1;
    repeat (400) step();
    bus.frame_tick = 1'b0;
    check("ovr_saturate", 32'(bus.overrun_count), 32'hFF);
    wait_idle("sat");
    check("sat_hold", 32'(bus.overrun_count), 32'hFF);
    check("sat_collis1", bus.collis1, 32'h5);
    check("sat_collis2", bus.collis2, 32'h5);

    // Reset during SLOT2: abort, no done pulse afterwards.
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
    step();
    check("mid_in_slot2_ppos", bus.player_pos_out, 32'h00400020);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    check("mid_rst_collis1", bus.collis1, 32'h0);
    check("mid_rst_collis2", bus.collis2, 32'h0);
    check("mid_rst_overrun", 32'(bus.overrun_count), 32'h0);
    check("mid_rst_ppos", bus.player_pos_out, 32'h0);
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    check("mid_rst_quiet", 32'(done_seen), 32'h0);
    check("mid_rst_collis1_hold", bus.collis1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Time-multiplexes the single shared collision unit between player 1 and player 2 physics coprocessors, once per frame.
- On each frame tick it snapshots both player positions.
- It then drives each player's position and size into the collision unit in turn, waits a settle window, and latches the 4-bit result into that player's collision register.
- It sits in the MMIO block between the physics coprocessor `position` outputs, the collision unit, and the physics `wall` inputs. It replaces the fixed P1-only wiring.

Parameters:
- SETTLE, 2, cycles each player's operands are held on the collision unit before capture (legal range 1..15)
- OVF_W, 8, width of the saturating overrun counter

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse starting a collision pass
- p2_enable  in  1  1 = run the P2 slot; 0 = P1 only
- pos1, pos2  in  32  player positions {x[31:16], y[15:0]}
- size1, size2  in  32  player sizes {w[31:16], h[15:0]}
- stage_pos_in, stage_size_in  in  32  stage rectangle, passed through
- coll_in  in  4  result from the shared collision unit (combinational)
- player_pos_out, player_size_out  out  32  operands to the collision unit
- stage_pos_out, stage_size_out  out  32  stage operands to the collision unit
- collis1, collis2  out  32  latched results, zero-extended; feed physics `wall`
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a pass completes
- overrun_count  out  OVF_W  ticks dropped while busy, saturating

Behaviour:
- States: IDLE, SLOT1, SLOT2, DONE.
- Reset values: state=IDLE; collis1=collis2=0; busy=0; done=0; overrun_count=0; snapshots=0. All operand outputs are therefore 0.
- Reset mid-pass: the pass is aborted, no capture occurs, and the reset values apply on the next cycle.
- IDLE:
  - On frame_tick at edge T: snap1<=pos1, snap2<=pos2, sz1<=size1, sz2<=size2; next state SLOT1, counter<=0.
  - Stage inputs are registered on every tick.
- SLOT1:
  - player_pos_out=snap1, player_size_out=sz1.
  - The counter increments each cycle.
  - On the edge ending the SETTLE-th cycle: collis1<={28'b0, coll_in}.
  - Next state is SLOT2 if p2_enable, else DONE.
  - p2_enable is sampled at that edge.
- SLOT2: same as SLOT1 using snap2/sz2, capturing into collis2; next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE.
- When p2_enable=0 the pass skips SLOT2 and collis2 is cleared to 0 at the SLOT1→DONE edge.
- Latency with tick seen at edge T:
  - collis1 updates at T+SETTLE.
  - collis2 updates at T+2·SETTLE.
  - done is high in cycle T+2·SETTLE+1 (T+SETTLE+1 if P2 is skipped).
  - IDLE is re-entered one cycle later.
- Operand outputs:
  - In IDLE and DONE they hold the last driven slot's operands; after reset this is snap1/sz1 = 0.
  - stage_*_out are always the registered stage values.
- frame_tick in any non-IDLE state (including DONE) is ignored and overrun_count increments. At 2^OVF_W−1 the counter holds.
- Positions are snapshotted, so mid-pass changes to pos1/pos2 have no effect on the current pass.
- collis1 and collis2 hold their values between passes. They change only at a capture edge, a P2-skip clear, or reset.

Decomposition:
- Shared package:
  - state encoding (IDLE=0, SLOT1=1, SLOT2=2, DONE=3)
  - COLL_W=4
  - field slice constants for the {x,y}/{w,h} packing
- One sub-module, settle_timer:
  - load/enable, 4-bit count, `expired` output
  - asserts `expired` in the SETTLE-th cycle after load
  - reused per slot

Test Plan:
- Reset, then idle 10 cycles → all outputs 0, busy=0, done=0.
- SETTLE=2, p2_enable=1, pos1=32'h016000FA, pos2=32'h00400020, coll_in=4'h1 in SLOT1 and 4'h8 in SLOT2, tick at T → collis1=32'h1 at T+2, collis2=32'h8 at T+4, done high at T+5 only, busy high T+1..T+5.
- p2_enable=0, coll_in=4'h4 → collis1=32'h4, collis2=0, done at T+3; player_pos_out never shows snap2.
- Change pos1 to 32'h0 during SLOT1 → player_pos_out stays 32'h016000FA for the whole slot.
- Ticks at T, T+1, T+4 (pass busy) → one pass only, overrun_count=2; 300 ticks while busy → counter saturates at 255.
- Assert reset in SLOT2 → next cycle state IDLE, collis1=collis2=0, no done pulse.
